// File: rtl/cbm_step_scheduler_pkg.sv
// ============================================================================
// Module   : cbm_step_scheduler_pkg
// Purpose  : Shared definitions for the CBM step scheduler: default datapath
//            geometry (NI, WR mirror Parameter.vh) and the scheduler FSM
//            state encoding.
// Contents : c_NI, c_WR, c_NSUB defaults; schedState_t (IDLE/LOAD/RUN/DONE)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cbm_step_scheduler_pkg;

    // Defaults mirrored from Parameter.vh (DECLARE_PARAMETERS)
    localparam int c_NI   = 4;      // input-state element count
    localparam int c_WR   = 8;      // bits per element
    localparam int c_NSUB = 256;    // encoder beats per time step

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } schedState_t;

endpackage

`default_nettype wire

// File: rtl/cbm_step_scheduler_substep_counter.sv
// ============================================================================
// Module   : SubstepCounter
// Purpose  : Modulo-NSUB beat counter for one reservoir time step.
//            Clear has priority over enable. oTerminal is combinational and
//            flags the beat that carries the count NSUB-1 (only when enabled).
// Ports    : clk, rst (async, active-high), iClear, iEnable -> oTerminal
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module SubstepCounter
    import cbm_step_scheduler_pkg::*;
#(
    parameter int NSUB = c_NSUB
) (
    input  logic clk,
    input  logic rst,
    input  logic iClear,
    input  logic iEnable,
    output logic oTerminal
);

    localparam int CW = (NSUB > 1) ? $clog2(NSUB) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(NSUB - 1);

    logic [CW-1:0] r_count;

    assign oTerminal = iEnable && (r_count == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (iClear) begin
            r_count <= '0;
        end else if (iEnable) begin
            // Explicit wrap so non-power-of-two NSUB still counts 0..NSUB-1
            r_count <= oTerminal ? '0 : r_count + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cbm_step_scheduler.sv
// ============================================================================
// Module   : cbm_step_scheduler
// Purpose  : Sequences reservoir time steps into the CBM encoder. Each step
//            accepts one input-state word upstream, holds it, and replays it
//            on the encoder input-state channel for exactly NSUB beats.
//            A host start pulse launches a run of iNumSteps steps.
// Ports    : iCLK, iRST (async, active-high)
//            iStart, iNumSteps          run control
//            oBusy, oStepDone, oRunDone, oStepCount, oWashout  status
//            *_AS_InputState            upstream sample channel (valid/ready)
//            *_BM_InputState            encoder input-state channel
// Options  : CBM_SCHED_WASHOUT_EN - flag the first WASHOUT steps on oWashout;
//            when undefined oWashout is tied low.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cbm_step_scheduler
    import cbm_step_scheduler_pkg::*;
#(
    parameter int NI      = c_NI,
    parameter int WR      = c_WR,
    parameter int NSUB    = c_NSUB,
    parameter int SW      = 16,
    parameter int WASHOUT = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [SW-1:0]    iNumSteps,
    output logic             oBusy,
    output logic             oStepDone,
    output logic             oRunDone,
    output logic [SW-1:0]    oStepCount,
    output logic             oWashout,
    input  logic             iValid_AS_InputState,
    output logic             oReady_AS_InputState,
    input  logic [NI*WR-1:0] iData_AS_InputState,
    output logic             oValid_BM_InputState,
    input  logic             iReady_BM_InputState,
    output logic [NI*WR-1:0] oData_BM_InputState
);

    localparam int c_DW = NI * WR;

    if (NSUB < 2) begin : g_nsubCheck
        $error("cbm_step_scheduler: NSUB must be at least 2");
    end
    if (WASHOUT < 0) begin : g_washoutCheck
        $error("cbm_step_scheduler: WASHOUT must be non-negative");
    end

    schedState_t     r_state;
    logic [SW-1:0]   r_numSteps;
    logic [SW-1:0]   r_stepCount;
    logic [c_DW-1:0] r_hold;
    logic            r_busy;
    logic            r_readyAs;
    logic            r_validBm;
    logic            r_runDone;

    logic            w_upXfer;
    logic            w_beat;
    logic            w_lastBeat;
    logic [SW-1:0]   w_nextCount;

    // r_readyAs is high exactly in LOAD, r_validBm exactly in RUN
    assign w_upXfer    = r_readyAs & iValid_AS_InputState;
    assign w_beat      = r_validBm & iReady_BM_InputState;
    assign w_nextCount = r_stepCount + SW'(1);

    SubstepCounter #(
        .NSUB (NSUB)
    ) u_substep (
        .clk       (iCLK),
        .rst       (iRST),
        .iClear    (w_upXfer),
        .iEnable   (w_beat),
        .oTerminal (w_lastBeat)
    );

    // FSM with the handshake/status flags registered alongside the state
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state     <= ST_IDLE;
            r_numSteps  <= '0;
            r_stepCount <= '0;
            r_hold      <= '0;
            r_busy      <= 1'b0;
            r_readyAs   <= 1'b0;
            r_validBm   <= 1'b0;
            r_runDone   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_stepCount <= '0;
                        r_busy      <= 1'b1;
                        if (iNumSteps != '0) begin
                            r_numSteps <= iNumSteps;
                            r_readyAs  <= 1'b1;
                            r_state    <= ST_LOAD;
                        end else begin
                            r_runDone  <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_upXfer) begin
                        r_hold    <= iData_AS_InputState;
                        r_readyAs <= 1'b0;
                        r_validBm <= 1'b1;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_lastBeat) begin
                        r_stepCount <= w_nextCount;
                        r_validBm   <= 1'b0;
                        if (w_nextCount == r_numSteps) begin
                            r_runDone <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_readyAs <= 1'b1;
                            r_state   <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    r_runDone <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oBusy                = r_busy;
    assign oRunDone             = r_runDone;
    assign oStepCount           = r_stepCount;
    assign oReady_AS_InputState = r_readyAs;
    assign oValid_BM_InputState = r_validBm;
    // Final-beat pulse must coincide with the beat itself, so it is decoded
    assign oStepDone            = w_lastBeat;
    // Hold register is only exposed while the step is being replayed
    assign oData_BM_InputState  = r_validBm ? r_hold : '0;

`ifdef CBM_SCHED_WASHOUT_EN
    assign oWashout = r_busy && (int'(r_stepCount) < WASHOUT);
`else
    assign oWashout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/cbm_step_scheduler.md
# cbm_step_scheduler

Sequences one reservoir time step through the CBM encoder datapath. Accepts one input-state word per time step, holds it, and replays it toward the encoder's input-state channel for exactly NSUB sub-step beats, then releases it and accepts the next word. Counts time steps over a run started by a host pulse and reports completion. Sits between the sample source and the encoder's input-state port; the output-state feedback channel does not pass through this block.

## Interface
- NI, 4: input-state element count; from `Parameter.vh` via `DECLARE_PARAMETERS`.
- WR, 8: bits per element; from `Parameter.vh`.
- NSUB, 256: encoder beats per time step; must be at least 2.
- SW, 16: step-counter width.
- WASHOUT, 8: washout steps; used only under `CBM_SCHED_WASHOUT_EN`.
- iCLK  in  1  clock; all state on rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iStart  in  1  single-cycle run request; honoured only in IDLE.
- iNumSteps  in  SW  steps in the run; sampled on an accepted iStart; 0 means no steps.
- oBusy  out  1  high in any state other than IDLE.
- oStepDone  out  1  one-cycle pulse when a step's final beat transfers.
- oRunDone  out  1  one-cycle pulse when the run ends.
- oStepCount  out  SW  steps completed in the current run.
- oWashout  out  1  current step is a washout step.
- iValid_AS_InputState  in  1  upstream sample valid.
- oReady_AS_InputState  out  1  upstream sample ready.
- iData_AS_InputState  in  NI*WR  upstream sample.
- oValid_BM_InputState  out  1  toward the encoder combiner.
- iReady_BM_InputState  in  1  from the encoder combiner.
- oData_BM_InputState  out  NI*WR  held sample.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE
  - iStart=1 with iNumSteps≠0: latch N=iNumSteps, clear oStepCount, go to LOAD.
  - iStart=1 with iNumSteps=0: go to DONE.
- LOAD
  - oReady_AS_InputState=1.
  - On upstream transfer (valid&ready): capture data into the hold register, clear the beat counter, go to RUN.
- RUN
  - oValid_BM_InputState=1; oData_BM_InputState = hold register (stable for the whole step).
  - Beat = oValid_BM&iReady_BM. The beat counter increments on each beat and ranges 0..NSUB-1.
  - On the beat with counter = NSUB-1:
    - pulse oStepDone;
    - increment oStepCount;
    - if the new count equals N, go to DONE; otherwise go to LOAD.
- DONE: pulse oRunDone for one cycle, then go to IDLE.
- Outputs are 0 in every state that does not drive them (for example, oReady_AS_InputState=0 outside LOAD).
- iStart is ignored while oBusy=1.
- iNumSteps is not re-sampled mid-run.
- oStepCount holds its final value in IDLE until the next accepted start.
- oStepCount increments modulo 2^SW; N ≤ 2^SW-1 by construction.
- Upstream back-pressure in LOAD stalls the run indefinitely; no timeout.
- Reset mid-run: return to IDLE immediately; the partial step is discarded; no oStepDone or oRunDone pulse.

## Timing
- Reset values: every output 0, oData_BM_InputState 0, FSM in IDLE, all counters 0.
- Cycle after the accepted iStart: in LOAD.
- Upstream transfer in cycle t: oValid_BM=1 in cycle t+1.
- Minimum step length with iReady_BM held at 1: 1 LOAD cycle + NSUB RUN cycles.
- oStepDone is asserted in the same cycle as the final beat.
- oRunDone is asserted in the cycle after the final oStepDone.
- oBusy falls one cycle after oRunDone.
- oValid_BM_InputState never drops while oValid_BM=1 and iReady_BM=0; the hold data is stable under stall.
- The hold register is written only on an upstream transfer.

## Configuration
- `CBM_SCHED_WASHOUT_EN` defined: oWashout=1 while oBusy and oStepCount<WASHOUT, so the first WASHOUT steps are flagged for the readout to discard.
- `CBM_SCHED_WASHOUT_EN` undefined: oWashout is tied to 0, the comparator is removed, and WASHOUT is unused.

## Structure
- Shared package: the FSM state encoding constants (IDLE/LOAD/RUN/DONE) and the NSUB default, alongside NI/WR in `Parameter.vh`.
- One sub-module, `SubstepCounter`:
  - parameterised modulo-NSUB counter with a clear input and an enable input;
  - terminal-count output, asserted combinationally at count NSUB-1 when enabled.
- Top level holds the FSM, the hold register and the step counter.

## Test plan
- Reset, then start with NSUB=4, iNumSteps=2, upstream data 0x11 then 0x22, iReady_BM=1:
  - 0x11 for beats 1–4 and 0x22 for beats 5–8;
  - oStepDone on beats 4 and 8, oStepCount 1 then 2;
  - oRunDone one cycle after beat 8.
- Same run with iReady_BM toggling 1,0,1,0: data and oValid_BM stable across stalls; exactly 4 beats per step.
- iNumSteps=0: oRunDone one cycle after start; no upstream transfer; oStepCount=0.
- iRST asserted at beat 2 of step 1: all outputs 0 immediately; no pulses; a fresh start runs normally.
- iStart pulsed while busy: ignored; the run length stays at the originally latched N.
- With the macro defined, WASHOUT=1, N=3: oWashout high for step 1 only. Without the macro: oWashout stays 0 throughout.
